id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word bit positions, widths and the ID/EX control bundle.
package pipe_pkg;

   localparam int unsigned CTRL_W = 9;
   localparam int unsigned FLAG_W = 5;

   localparam int unsigned CTRL_MEMTOREG = 8;
   localparam int unsigned CTRL_REGWRITE = 7;
   localparam int unsigned CTRL_BRANCH   = 6;
   localparam int unsigned CTRL_MEMREAD  = 5;
   localparam int unsigned CTRL_MEMWRITE = 4;
   localparam int unsigned CTRL_REGDST   = 3;
   localparam int unsigned CTRL_ALUSRC   = 2;
   localparam int unsigned CTRL_RTYPE    = 1;
   localparam int unsigned CTRL_BEQ      = 0;

   localparam int unsigned FLAG_IMM = 3;

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [FLAG_W-1:0] flags;
   } id_ex_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX is writing.
module hazard_detect #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              ex_valid,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_imm,
   input  logic              id_alusrc,
   input  logic              id_memwrite,
   output logic              load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = (ex_rt == id_rs);
   // rt is only a source for register-register ops or as store data
   assign rt_hit = (ex_rt == id_rt) & ((~id_imm & ~id_alusrc) | id_memwrite);

   assign load_use = ex_valid & ex_memread & id_valid & (ex_rt != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, external stall and optional load-use bubble insertion.
// Optional feature macro: ID_EX_HAZARD_DETECT_EN (load-use detection; tied off when undefined).
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] rs_data_in,
   input  logic [DATA_W-1:0] rt_data_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [DATA_W-1:0] pc4_in,
   input  logic [REG_AW-1:0] rs_in,
   input  logic [REG_AW-1:0] rt_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic              flush,
   input  logic              ext_stall,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [FLAG_W-1:0] flags_out,
   output logic [DATA_W-1:0] rs_data_out,
   output logic [DATA_W-1:0] rt_data_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] pc4_out,
   output logic [REG_AW-1:0] rs_out,
   output logic [REG_AW-1:0] rt_out,
   output logic [REG_AW-1:0] rd_out,
   output logic              ex_valid,
   output logic              id_stall
);

   typedef struct packed {
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc4;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
   } data_t;

   id_ex_t ctl_q, ctl_d;
   data_t  data_q, data_d;
   logic   pend_q, pend_d;
   logic   load_use;

`ifdef ID_EX_HAZARD_DETECT_EN
   hazard_detect #(
      .REG_AW(REG_AW)
   ) u_hazard_detect (
      .ex_valid   (ctl_q.valid),
      .ex_memread (ctl_q.ctrl[CTRL_MEMREAD]),
      .ex_rt      (data_q.rt),
      .id_valid   (id_valid),
      .id_rs      (rs_in),
      .id_rt      (rt_in),
      .id_imm     (flags_in[FLAG_IMM]),
      .id_alusrc  (ctrl_in[CTRL_ALUSRC]),
      .id_memwrite(ctrl_in[CTRL_MEMWRITE]),
      .load_use   (load_use)
   );
`else
   assign load_use = 1'b0;
`endif

   assign id_stall = load_use | ext_stall;

   always_comb begin
      ctl_d  = ctl_q;
      data_d = data_q;
      pend_d = pend_q;
      if (ext_stall) begin
         // a flush seen while held must still squash once the hold lifts
         pend_d = pend_q | flush;
      end else if (flush | pend_q | load_use) begin
         ctl_d  = '0;
         data_d = '0;
         pend_d = 1'b0;
      end else begin
         ctl_d.valid = id_valid;
         ctl_d.ctrl  = id_valid ? ctrl_in : '0;
         ctl_d.flags = id_valid ? flags_in : '0;
         data_d      = '{rs_data: rs_data_in, rt_data: rt_data_in, imm: imm_in, pc4: pc4_in,
                         rs: rs_in, rt: rt_in, rd: rd_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q  <= '0;
         data_q <= '0;
         pend_q <= 1'b0;
      end else begin
         ctl_q  <= ctl_d;
         data_q <= data_d;
         pend_q <= pend_d;
      end
   end

   assign ctrl_out    = ctl_q.ctrl;
   assign flags_out   = ctl_q.flags;
   assign ex_valid    = ctl_q.valid;
   assign rs_data_out = data_q.rs_data;
   assign rt_data_out = data_q.rt_data;
   assign imm_out     = data_q.imm;
   assign pc4_out     = data_q.pc4;
   assign rs_out      = data_q.rs;
   assign rt_out      = data_q.rt;
   assign rd_out      = data_q.rd;

endmodule
